exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter EXEC_LATENCY, default 1, ALU settle cycles per instruction (legal 1..15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  sequencer accepts this cycle.
- in_control  in  InstructionControl  alu_op, alu_src2, is_ebreak.
- in_dst, in_src1, in_src2  in  RegAddress  register operands.
- in_imm  in  Immediate  immediate operand.
- rf_src1, rf_src2  out  RegAddress  register file read addresses.
- rf_v1, rf_v2  in  Word  register file read data (combinational).
- rf_dst  out  RegAddress  write address.
- rf_write_enable  out  1  write strobe.
- rf_write_data  out  Word  write data.
- alu_op  out  AluOp  ALU operation.
- alu_a, alu_b  out  Word  ALU operands.
- alu_result  in  Word  ALU output.
- alu_error  in  1  ALU error flag.
- halted  out  1  ebreak retired.
- error  out  1  sticky ALU error.
- retired  out  32  retired-instruction count (macro only, REQ-019).

Function
REQ-003 SHALL implement states IDLE, READ, EXEC, WRITE, HALT, ERROR.
REQ-004 SHALL drive in_ready=1 only in IDLE; a transfer occurs at an edge where in_valid and in_ready are both 1, and all in_* fields are captured into internal registers at that edge.
REQ-005 SHALL go IDLE->HALT on a transfer with is_ebreak=1; otherwise IDLE->READ.
REQ-006 SHALL in READ drive rf_src1/rf_src2 from captured src1/src2, latch rf_v1 and rf_v2 at the edge, then go to EXEC.
REQ-007 SHALL in EXEC drive alu_op from the captured control, alu_a=latched v1, and alu_b=Word'(imm) when alu_src2==ALU2_IMM, else latched v2.
REQ-008 SHALL hold EXEC for exactly EXEC_LATENCY cycles; at the final EXEC edge it latches alu_result and goes to WRITE, or to ERROR if alu_error=1.
REQ-009 SHALL in WRITE drive rf_dst=captured dst and rf_write_data=latched result for one cycle, with rf_write_enable=1 unless dst==0, then go to IDLE.
REQ-010 SHALL give the following latency for a transfer at edge 0: register file updated at edge 2+EXEC_LATENCY; next transfer no earlier than edge 3+EXEC_LATENCY.
REQ-011 SHALL make an instruction read its source registers after the previous instruction's write has committed, so no hazard logic is needed.
REQ-012 SHALL make HALT and ERROR terminal (exit only via reset), with in_ready=0, rf_write_enable=0, halted=1 in HALT, and error=1 in ERROR.
REQ-013 SHALL drive rf_write_enable=0 in every state other than WRITE.
REQ-014 SHALL ignore in_valid with in_ready=0; in_* fields may change freely then.

Reset
REQ-015 SHALL, on reset_n=0 at any time (including mid-instruction), enter IDLE asynchronously and discard the captured instruction, with no write issued.
REQ-016 SHALL hold these values during reset: in_ready=0, rf_write_enable=0, halted=0, error=0, retired=0, all address/data outputs 0.
REQ-017 SHALL assert in_ready in the first cycle after reset_n deasserts.

Configuration
REQ-018 SHALL provide macro EXEC_SEQUENCER_PERF_EN.
REQ-019 SHALL, when EXEC_SEQUENCER_PERF_EN is defined, include a 32-bit retired counter that increments at each WRITE->IDLE edge (including dst==0) and wraps 0xFFFFFFFF->0; ebreak does not count.
REQ-020 SHALL, when EXEC_SEQUENCER_PERF_EN is undefined, omit the retired port and counter entirely, leaving all other behaviour identical.

Structure
REQ-021 SHALL place the state enum and the EXEC_LATENCY bounds in a shared sequencer package; Word, RegAddress, AluOp, Immediate and InstructionControl come from the existing shared type headers.
REQ-022 SHALL use one sub-module, seq_wait_counter, as a loadable down-counter that times EXEC.

Verification
REQ-023 SHALL cover the following directed scenarios:
- Program ADDI r1,r0,10; ADDI r1,r1,40; ADDI r2,r1,10; ADDI r3,r2,1; ADDI r4,r3,1; SUB r5,r4,r1; AND r6,r1,r2; EBREAK, all offered back-to-back -> r1=50, r2=60, r3=61, r4=62, r5=12, r6=48, halted=1.
- EXEC_LATENCY=1, single ADDI at edge 0 -> rf_write_enable high only in cycle 3, in_ready low in cycles 1..3.
- ADDI r0,r0,5 -> rf_write_enable never asserted; r0 stays 0; retired +1 (macro on).
- alu_error=1 during EXEC -> error=1, no write, in_ready=0 until reset.
- reset_n pulsed low during EXEC of ADDI r7,r0,9 -> r7 unchanged, state IDLE, in_ready=1 after release.
- Macro on, retired preset to 0xFFFFFFFF by forcing, one retire -> retired=0.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared types for the execute sequencer: datapath words, register addresses,
// ALU control, sequencer states and EXEC_LATENCY bounds.
package exec_sequencer_pkg;

  typedef logic [31:0]        Word;
  typedef logic [4:0]         RegAddress;
  typedef logic signed [11:0] Immediate;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } AluOp;

  typedef enum logic {
    ALU2_REG = 1'b0,
    ALU2_IMM = 1'b1
  } AluSrc2;

  typedef struct packed {
    AluOp   alu_op;
    AluSrc2 alu_src2;
    logic   is_ebreak;
  } InstructionControl;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    HALT  = 3'd4,
    ERROR = 3'd5
  } seq_state_e;

  localparam int unsigned EXEC_LATENCY_MIN = 1;
  localparam int unsigned EXEC_LATENCY_MAX = 15;
  localparam int unsigned WAIT_W           = 4;

  // Out-of-range latencies are pinned to the nearest legal bound.
  function automatic logic [WAIT_W-1:0] wait_load_value(input int unsigned latency);
    int unsigned lat;
    lat = latency;
    if (lat < EXEC_LATENCY_MIN) begin
      lat = EXEC_LATENCY_MIN;
    end else if (lat > EXEC_LATENCY_MAX) begin
      lat = EXEC_LATENCY_MAX;
    end else begin
      lat = latency;
    end
    return WAIT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/exec_sequencer_wait_counter.sv
// seq_wait_counter: loadable down-counter; zero_o marks the final EXEC cycle.
module seq_wait_counter
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over decrement, saturating at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {WIDTH{1'b0}})) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> READ -> EXEC(xN) -> WRITE, with
// terminal HALT/ERROR. Optional retired counter under EXEC_SEQUENCER_PERF_EN.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  InstructionControl in_control,
  input  RegAddress         in_dst,
  input  RegAddress         in_src1,
  input  RegAddress         in_src2,
  input  Immediate          in_imm,
  output RegAddress         rf_src1,
  output RegAddress         rf_src2,
  input  Word               rf_v1,
  input  Word               rf_v2,
  output RegAddress         rf_dst,
  output logic              rf_write_enable,
  output Word               rf_write_data,
  output AluOp              alu_op,
  output Word               alu_a,
  output Word               alu_b,
  input  Word               alu_result,
  input  logic              alu_error,
  output logic              halted,
  output logic              error
`ifdef EXEC_SEQUENCER_PERF_EN
  ,
  output logic [31:0]       retired
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = wait_load_value(EXEC_LATENCY);

  seq_state_e state_q, state_d;
  AluOp       op_q, op_d;
  AluSrc2     src2_sel_q, src2_sel_d;
  RegAddress  dst_q, dst_d;
  RegAddress  src1_q, src1_d;
  RegAddress  src2_q, src2_d;
  Immediate   imm_q, imm_d;
  Word        v1_q, v1_d;
  Word        v2_q, v2_d;
  Word        res_q, res_d;
  logic       wait_load;
  logic       wait_dec;
  logic       wait_zero;

  seq_wait_counter #(
    .WIDTH(WAIT_W)
  ) u_wait (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (wait_load),
    .load_val_i(WAIT_LOAD),
    .dec_i     (wait_dec),
    .zero_o    (wait_zero)
  );

  // Next-state and datapath capture logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src2_sel_d = src2_sel_q;
    dst_d      = dst_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm_d      = imm_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    res_d      = res_q;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = in_control.alu_op;
          src2_sel_d = in_control.alu_src2;
          dst_d      = in_dst;
          src1_d     = in_src1;
          src2_d     = in_src2;
          imm_d      = in_imm;
          state_d    = in_control.is_ebreak ? HALT : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        v1_d      = rf_v1;
        v2_d      = rf_v2;
        wait_load = 1'b1;
        state_d   = EXEC;
      end
      EXEC: begin
        if (wait_zero) begin
          res_d   = alu_result;
          state_d = alu_error ? ERROR : WRITE;
        end else begin
          wait_dec = 1'b1;
          state_d  = EXEC;
        end
      end
      WRITE:   state_d = IDLE;
      HALT:    state_d = HALT;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-instruction registers; reset discards any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= ALU_ADD;
      src2_sel_q <= ALU2_REG;
      dst_q      <= 5'd0;
      src1_q     <= 5'd0;
      src2_q     <= 5'd0;
      imm_q      <= 12'sd0;
      v1_q       <= 32'd0;
      v2_q       <= 32'd0;
      res_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src2_sel_q <= src2_sel_d;
      dst_q      <= dst_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      res_q      <= res_d;
    end
  end

  // Output decode from registered state; in_ready is gated so it stays low while reset is held.
  always_comb begin
    in_ready        = 1'b0;
    rf_src1         = 5'd0;
    rf_src2         = 5'd0;
    rf_dst          = 5'd0;
    rf_write_enable = 1'b0;
    rf_write_data   = 32'd0;
    alu_op          = ALU_ADD;
    alu_a           = 32'd0;
    alu_b           = 32'd0;
    halted          = 1'b0;
    error           = 1'b0;
    case (state_q)
      IDLE: in_ready = reset_n;
      READ: begin
        rf_src1 = src1_q;
        rf_src2 = src2_q;
      end
      EXEC: begin
        alu_op = op_q;
        alu_a  = v1_q;
        alu_b  = (src2_sel_q == ALU2_IMM) ? Word'(imm_q) : v2_q;
      end
      WRITE: begin
        rf_dst          = dst_q;
        rf_write_data   = res_q;
        rf_write_enable = (dst_q != 5'd0);
      end
      HALT:    halted = 1'b1;
      ERROR:   error  = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

`ifdef EXEC_SEQUENCER_PERF_EN
  logic [31:0] retired_q;

  // Retired count: one per WRITE->IDLE edge, including writes to r0; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= 32'd0;
    end else if (state_q == WRITE) begin
      retired_q <= retired_q + 32'd1;
    end else begin
      retired_q <= retired_q;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: environment register file and ALU, a reference
// model that predicts each register write, and a scoreboard monitor.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  localparam int unsigned LAT = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  InstructionControl in_control = '{alu_op: ALU_ADD, alu_src2: ALU2_REG, is_ebreak: 1'b0};
  RegAddress         in_dst = 5'd0, in_src1 = 5'd0, in_src2 = 5'd0;
  Immediate          in_imm = 12'sd0;
  RegAddress         rf_src1, rf_src2, rf_dst;
  Word               rf_v1, rf_v2, rf_write_data;
  logic              rf_write_enable;
  AluOp              alu_op;
  Word               alu_a, alu_b, alu_result;
  logic              alu_error;
  logic              halted, error;
  logic              inj_err = 1'b0;
`ifdef EXEC_SEQUENCER_PERF_EN
  logic [31:0]       retired;
`endif

  typedef struct {
    RegAddress dst;
    Word       data;
  } wr_t;

  wr_t         exp_q[$];
  Word         rf_mem  [32] = '{default: 32'd0};
  Word         ref_regs[32] = '{default: 32'd0};
  logic [31:0] exp_retired = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  exec_sequencer #(.EXEC_LATENCY(LAT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_control     (in_control),
    .in_dst         (in_dst),
    .in_src1        (in_src1),
    .in_src2        (in_src2),
    .in_imm         (in_imm),
    .rf_src1        (rf_src1),
    .rf_src2        (rf_src2),
    .rf_v1          (rf_v1),
    .rf_v2          (rf_v2),
    .rf_dst         (rf_dst),
    .rf_write_enable(rf_write_enable),
    .rf_write_data  (rf_write_data),
    .alu_op         (alu_op),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_result     (alu_result),
    .alu_error      (alu_error),
    .halted         (halted),
    .error          (error)
`ifdef EXEC_SEQUENCER_PERF_EN
    ,
    .retired        (retired)
`endif
  );

  always #5 clk = ~clk;

  function automatic Word alu_fn(input AluOp op, input Word a, input Word b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign rf_v1      = rf_mem[rf_src1];
  assign rf_v2      = rf_mem[rf_src2];
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_error  = inj_err;

  always @(posedge clk) begin
    if (rf_write_enable && rf_dst != 5'd0) rf_mem[rf_dst] <= rf_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && rf_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: dst=%0d data=%h required no write", rf_dst, rf_write_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_dst", 32'(rf_dst), 32'(e.dst));
          check("wr_data", rf_write_data, e.data);
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input AluOp op, input bit use_imm, input bit ebrk, input int dst,
                       input int s1, input int s2, input int imm, input bit commit,
                       input bit keep_valid);
    Word b;
    Word r;
    @(negedge clk);
    wait_ready("issue_ready");
    in_control = '{alu_op: op, alu_src2: (use_imm ? ALU2_IMM : ALU2_REG), is_ebreak: ebrk};
    in_dst   = RegAddress'(dst);
    in_src1  = RegAddress'(s1);
    in_src2  = RegAddress'(s2);
    in_imm   = Immediate'(imm);
    in_valid = 1'b1;
    if (!ebrk && commit) begin
      b = use_imm ? Word'(imm) : ref_regs[s2];
      r = alu_fn(op, ref_regs[s1], b);
      exp_retired = exp_retired + 32'd1;
      if (dst != 0) begin
        exp_q.push_back('{dst: RegAddress'(dst), data: r});
        ref_regs[dst] = r;
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    in_dst  = RegAddress'($urandom);
    in_src1 = RegAddress'($urandom);
    in_src2 = RegAddress'($urandom);
    in_imm  = Immediate'($urandom);
    in_control.is_ebreak = 1'($urandom);
  endtask

  task automatic op_i(input AluOp op, input int dst, input int s1, input int imm);
    issue(op, 1'b1, 1'b0, dst, s1, 0, imm, 1'b1, 1'b0);
  endtask

  task automatic op_r(input AluOp op, input int dst, input int s1, input int s2);
    issue(op, 1'b0, 1'b0, dst, s1, s2, 0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(rf_write_enable), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_wdata", rf_write_data, 32'd0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("rst_retired", retired, 32'd0);
`endif
    exp_retired = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    do_reset();

    // Latency: transfer at edge 0, write in cycle 2+LAT, ready again in cycle 3+LAT.
    issue(ALU_ADD, 1'b1, 1'b0, 8, 0, 0, -3, 1'b1, 1'b1);
    for (int k = 1; k <= 3 + int'(LAT); k++) begin
      @(negedge clk);
      check($sformatf("lat_ready_c%0d", k), 32'(in_ready), 32'(k == 3 + int'(LAT)));
      check($sformatf("lat_we_c%0d", k), 32'(rf_write_enable), 32'(k == 2 + int'(LAT)));
      if (k == 1) check("read_src1", 32'(rf_src1), 32'd0);
      if (k == 2) check("exec_alu_b_sext", alu_b, 32'hFFFF_FFFD);
      if (k == 2 + int'(LAT)) in_valid = 1'b0;
    end

    // Directed program ending in EBREAK.
    op_i(ALU_ADD, 1, 0, 10);
    op_i(ALU_ADD, 1, 1, 40);
    op_i(ALU_ADD, 2, 1, 10);
    op_i(ALU_ADD, 3, 2, 1);
    op_i(ALU_ADD, 4, 3, 1);
    op_r(ALU_SUB, 5, 4, 1);
    op_r(ALU_AND, 6, 1, 2);
    issue(ALU_ADD, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_ready", 32'(in_ready), 32'd0);
    check("halt_error", 32'(error), 32'd0);
    in_valid = 1'b1;
    in_dst   = 5'd9;
    repeat (4) @(negedge clk);
    check("halt_sticky", 32'(halted), 32'd1);
    in_valid = 1'b0;
    check("prog_r1", rf_mem[1], 32'd50);
    check("prog_r2", rf_mem[2], 32'd60);
    check("prog_r3", rf_mem[3], 32'd61);
    check("prog_r4", rf_mem[4], 32'd62);
    check("prog_r5", rf_mem[5], 32'd12);
    check("prog_r6", rf_mem[6], 32'd48);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("prog_retired", retired, 32'd8);
`endif

    // Write to r0 is retired but never strobed.
    do_reset();
    op_i(ALU_ADD, 0, 0, 5);
    @(negedge clk);
    wait_ready("r0_done");
    check("r0_zero", rf_mem[0], 32'd0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("r0_retired", retired, 32'd1);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    op_i(ALU_ADD, 9, 0, 1);
    @(negedge clk);
    wait_ready("wrap_done");
    check("retired_wrap", retired, exp_retired);
`endif

    // Reset during EXEC discards the instruction.
    op_i(ALU_ADD, 7, 0, 77);
    issue(ALU_ADD, 1'b1, 1'b0, 7, 0, 0, 9, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_we", 32'(rf_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("abort_post_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_r7", rf_mem[7], 32'd77);
    exp_retired = 32'd0;

    // ALU error is sticky and blocks the write.
    inj_err = 1'b1;
    issue(ALU_ADD, 1'b0, 1'b0, 3, 1, 2, 0, 1'b0, 1'b0);
    repeat (LAT + 3) @(negedge clk);
    check("err_flag", 32'(error), 32'd1);
    check("err_ready", 32'(in_ready), 32'd0);
    check("err_halted", 32'(halted), 32'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);
    in_valid = 1'b0;
    inj_err  = 1'b0;
    check("err_r3", rf_mem[3], 32'd61);
    do_reset();

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 150; i++) begin
      issue(AluOp'(3'($urandom_range(0, 4))), 1'($urandom), 1'b0,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)) - 2048,
            1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    wait_ready("rand_done");
    for (int r = 0; r < 32; r++) check($sformatf("final_r%0d", r), rf_mem[r], ref_regs[r]);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
`ifdef EXEC_SEQUENCER_PERF_EN
    check("rand_retired", retired, exp_retired);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
